// File: rtl/siso_shift_register.sv
// siso_shift_register: fixed-latency serial bit delay line
// with a parallel observation tap and a fill indicator.
module siso_shift_register #(
    parameter int   DEPTH       = 4,
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_in,
    output logic             serial_out,
    output logic [DEPTH-1:0] parallel_q,
    output logic             primed
);

    localparam int            CW   = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_d;

    if (DEPTH == 1) begin : g_one
        always_comb begin
            sr_d = serial_in;
        end
    end else begin : g_many
        always_comb begin
            sr_d = {sr_q[DEPTH-2:0], serial_in};
        end
    end

    // Saturates at DEPTH so primed holds until the next reset.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q != FULL) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q  <= {DEPTH{RESET_VALUE}};
            cnt_q <= '0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
        end
    end

    assign serial_out = sr_q[DEPTH-1];
    assign parallel_q = sr_q;
    assign primed     = (cnt_q == FULL);

endmodule

// File: tb/tb_siso_shift_register.sv
// Scoreboard bench: three siso_shift_register instances
// (4/RV0, 1/RV1, 8/RV1) driven from one serial stream.
module tb_siso_shift_register;

    logic       clk;
    logic       reset;
    logic       serial_in;
    logic       out4, out1, out8;
    logic [3:0] pq4;
    logic [0:0] pq1;
    logic [7:0] pq8;
    logic       pr4, pr1, pr8;

    int n_tests = 0;
    int n_fail  = 0;
    int cnt     = 0;

    logic q4[$];
    logic q1[$];
    logic q8[$];

    siso_shift_register #(.DEPTH(4), .RESET_VALUE(1'b0)) u_d4 (
        .clk(clk), .reset(reset), .serial_in(serial_in),
        .serial_out(out4), .parallel_q(pq4), .primed(pr4)
    );

    siso_shift_register #(.DEPTH(1), .RESET_VALUE(1'b1)) u_d1 (
        .clk(clk), .reset(reset), .serial_in(serial_in),
        .serial_out(out1), .parallel_q(pq1), .primed(pr1)
    );

    siso_shift_register #(.DEPTH(8), .RESET_VALUE(1'b1)) u_d8 (
        .clk(clk), .reset(reset), .serial_in(serial_in),
        .serial_out(out8), .parallel_q(pq8), .primed(pr8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Outputs before data arrives are RESET_VALUE: DEPTH-1 slots.
    task automatic sb_reset();
        q4.delete();
        q1.delete();
        q8.delete();
        for (int i = 0; i < 3; i++) q4.push_back(1'b0);
        for (int i = 0; i < 7; i++) q8.push_back(1'b1);
        cnt = 0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_out4"}, 64'(out4), 64'd0);
        chk({tag, "_pq4"}, 64'(pq4), 64'h0);
        chk({tag, "_pr4"}, 64'(pr4), 64'd0);
        chk({tag, "_out1"}, 64'(out1), 64'd1);
        chk({tag, "_pq1"}, 64'(pq1), 64'h1);
        chk({tag, "_pr1"}, 64'(pr1), 64'd0);
        chk({tag, "_out8"}, 64'(out8), 64'd1);
        chk({tag, "_pq8"}, 64'(pq8), 64'hff);
        chk({tag, "_pr8"}, 64'(pr8), 64'd0);
    endtask

    task automatic step(input logic b);
        logic e4, e1, e8;
        serial_in = b;
        q4.push_back(b);
        q1.push_back(b);
        q8.push_back(b);
        @(posedge clk);
        #1;
        cnt++;
        e4 = q4.pop_front();
        e1 = q1.pop_front();
        e8 = q8.pop_front();
        chk("out4", 64'(out4), 64'(e4));
        chk("out1", 64'(out1), 64'(e1));
        chk("out8", 64'(out8), 64'(e8));
        chk("pr4", 64'(pr4), 64'(cnt >= 4));
        chk("pr1", 64'(pr1), 64'(cnt >= 1));
        chk("pr8", 64'(pr8), 64'(cnt >= 8));
    endtask

    // Called 1 ns after an edge: pulse reset 3 ns, well clear of edges.
    task automatic pulse_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check_reset(tag);
        #2;
        reset = 1'b0;
        sb_reset();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] fill;
        logic [3:0] fill_exp[4];
        fill_exp[0] = 4'b0001;
        fill_exp[1] = 4'b0011;
        fill_exp[2] = 4'b0111;
        fill_exp[3] = 4'b1111;

        reset     = 1'b1;
        serial_in = 1'b0;
        #2;
        check_reset("rst_t2");
        @(posedge clk);
        #1;
        check_reset("rst_edge");
        #6;
        reset = 1'b0;
        sb_reset();

        step(1'b1);
        step(1'b0);
        step(1'b1);
        chk("pq4_35", 64'(pq4), 64'h5);
        step(1'b1);
        chk("pq4_45", 64'(pq4), 64'hb);
        for (int i = 0; i < 6; i++) step(1'b0);
        chk("pq4_drain", 64'(pq4), 64'h0);

        pulse_reset("r2");
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        chk("pq4_pre_mid", 64'(pq4), 64'hb);
        pulse_reset("mid");
        for (int i = 0; i < 9; i++) step(1'b0);

        pulse_reset("r3");
        for (int i = 0; i < 4; i++) begin
            step(1'b1);
            fill = pq4;
            chk("fill4", 64'(fill), 64'(fill_exp[i]));
        end
        for (int i = 0; i < 6; i++) step(1'b1);
        chk("pq8_ones", 64'(pq8), 64'hff);

        pulse_reset("r4");
        for (int i = 0; i < 20; i++) step(((i % 2) == 0) ? 1'b1 : 1'b0);
        chk("pq4_alt", 64'(pq4), 64'ha);
        chk("pq8_alt", 64'(pq8), 64'haa);

        for (int i = 0; i < 30; i++) step(1'($urandom_range(0, 1)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
